// File: rtl/ram_dump_reader.sv
// ram_dump_reader: walks a RAM address range and streams each byte with its address over a valid/ready port.
module ram_dump_reader #(
    parameter logic [3:0] START_ADDR  = 4'h0,
    parameter logic [3:0] END_ADDR    = 4'hF,
    parameter bit         AUTO_ON_HLT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       HLT,
    output logic       mem_rd,
    output logic [3:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic [7:0] dout,
    output logic [3:0] dout_addr,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, REQ, CAPT, SEND, FIN} state_t;
    state_t state, next;
    logic [3:0] cnt;
    logic hlt_q, trigger;
    always_comb begin
        next = state;
        trigger = start || (AUTO_ON_HLT && HLT && !hlt_q);
        case (state)
            IDLE:    next = trigger ? REQ : IDLE;
            REQ:     next = CAPT;
            CAPT:    next = SEND;
            SEND:    next = !dout_ready ? SEND : (cnt == END_ADDR ? FIN : REQ);
            FIN:     next = IDLE;
            default: next = IDLE;
        endcase
        // Outputs are gated by reset so they read 0 even before the first reset edge.
        mem_rd = reset && state == REQ;
        mem_addr = mem_rd ? cnt : 4'h0;
        dout_valid = reset && state == SEND;
        busy = reset && state != IDLE;
        done = reset && state == FIN;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= 4'h0;
            dout <= 8'h00;
            dout_addr <= 4'h0;
            hlt_q <= 1'b0;
        end else begin
            state <= next;
            hlt_q <= HLT;
            if (state == IDLE && trigger)
                cnt <= START_ADDR;
            else if (state == SEND && dout_ready && cnt != END_ADDR)
                cnt <= cnt + 4'd1;
            if (state == CAPT) begin
                dout <= mem_data;
                dout_addr <= cnt;
            end
        end
    end
endmodule

// File: tb/tb_ram_dump_reader.sv
// tb_ram_dump_reader: directed dumps with a queue scoreboard checked by a separate handshake monitor.
module tb_ram_dump_reader;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, HLT = 1'b0, dout_ready = 1'b1;
    logic start2 = 1'b0, hlt2 = 1'b0;
    logic mem_rd, mem_rd2, dout_valid, dout_valid2, busy, busy2, done, done2;
    logic [3:0] mem_addr, mem_addr2, dout_addr, dout_addr2;
    logic [7:0] mem_data = 8'h00, mem_data2 = 8'h00, dout, dout2;
    logic [7:0] ram [16];
    logic [11:0] exp_q[$], exp2_q[$];
    int checks = 0, errors = 0, done_cnt = 0, done2_cnt = 0;

    always #5 clk = ~clk;

    ram_dump_reader dut (
        .clk(clk), .reset(reset), .start(start), .HLT(HLT),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .dout(dout), .dout_addr(dout_addr), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy), .done(done)
    );

    ram_dump_reader #(.START_ADDR(4'h9), .END_ADDR(4'hA), .AUTO_ON_HLT(1'b1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .HLT(hlt2),
        .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_data(mem_data2),
        .dout(dout2), .dout_addr(dout_addr2), .dout_valid(dout_valid2),
        .dout_ready(dout_ready), .busy(busy2), .done(done2)
    );

    always @(posedge clk) begin
        if (mem_rd) mem_data <= ram[mem_addr];
        if (mem_rd2) mem_data2 <= ram[mem_addr2];
    end

    function automatic logic [7:0] exp_byte(input logic [3:0] a);
        return a == 4'h0 ? 8'h79 : a == 4'h9 ? 8'h0A : a == 4'hA ? 8'h0B : 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) chk("dump extra byte", 32'd1, 32'd0);
            else chk("dump byte {addr,data}", 32'({dout_addr, dout}), 32'(exp_q.pop_front()));
        end
        if (dout_valid2 && dout_ready) begin
            if (exp2_q.size() == 0) chk("dump2 extra byte", 32'd1, 32'd0);
            else chk("dump2 byte {addr,data}", 32'({dout_addr2, dout2}), 32'(exp2_q.pop_front()));
        end
        if (done) done_cnt++;
        if (done2) done2_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [3:0] lo, input logic [3:0] hi);
        for (int a = int'(lo); a <= int'(hi); a++) exp_q.push_back({4'(a), exp_byte(4'(a))});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_n);
        int n = 0;
        do begin tick(); n++; end while (!done && n < 200);
        if (exp_n >= 0) chk(name, 32'(n), 32'(exp_n));
        else chk(name, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_addr(input string name, input logic [3:0] a);
        int n = 0;
        while (!(dout_valid && dout_addr == a) && n < 200) begin tick(); n++; end
        chk(name, 32'(n < 200), 32'd1);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 16; i++) ram[i] = exp_byte(4'(i));
        tick();
        tick();
        chk("reset busy", 32'(busy), 0);
        chk("reset dout_valid", 32'(dout_valid), 0);
        chk("reset mem_rd", 32'(mem_rd), 0);
        chk("reset done", 32'(done), 0);
        chk("reset dout/dout_addr", 32'({dout_addr, dout}), 0);
        reset = 1'b1;
        tick();
        // full dump, ready tied high
        push_range(4'h0, 4'hF);
        pulse_start();
        chk("first mem_rd", 32'(mem_rd), 1);
        chk("first mem_addr", 32'(mem_addr), 0);
        chk("busy in dump", 32'(busy), 1);
        tick();
        chk("mem_addr outside REQ", 32'({mem_rd, mem_addr}), 0);
        tick();
        chk("first dout_valid at T+3", 32'(dout_valid), 1);
        wait_done("full dump done latency", 46);
        tick();
        chk("done pulses after dump A", 32'(done_cnt), 1);
        chk("busy after done", 32'(busy), 0);
        // stall on byte 9h
        push_range(4'h0, 4'hF);
        pulse_start();
        wait_addr("reach byte 9 for stall", 4'h9);
        dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall dout/addr", 32'({dout_valid, dout_addr, dout}), 32'({1'b1, 4'h9, 8'h0A}));
            chk("stall no mem_rd", 32'({mem_rd, mem_addr}), 0);
        end
        dout_ready = 1'b1;
        tick();
        chk("resume mem_rd/addr", 32'({mem_rd, mem_addr}), 32'({1'b1, 4'hA}));
        wait_done("stalled dump done", -1);
        tick();
        chk("done pulses after dump B", 32'(done_cnt), 2);
        // HLT rising edge, held high, with an ignored start
        push_range(4'h0, 4'hF);
        HLT = 1'b1;
        tick();
        chk("HLT edge starts dump", 32'({busy, mem_rd}), 32'(2'b11));
        tick();
        tick();
        pulse_start();
        wait_done("HLT dump done", -1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no second dump from held HLT/start", 32'({busy, mem_rd}), 0);
        end
        chk("done pulses after HLT dump", 32'(done_cnt), 3);
        HLT = 1'b0;
        push_range(4'h0, 4'hF);
        pulse_start();
        chk("fresh start mem_addr", 32'({mem_rd, mem_addr}), 32'({1'b1, 4'h0}));
        wait_done("fresh dump done", -1);
        tick();
        chk("done pulses after fresh dump", 32'(done_cnt), 4);
        // reset while presenting byte 5h
        push_range(4'h0, 4'h4);
        pulse_start();
        wait_addr("reach byte 5 for reset", 4'h5);
        d0 = done_cnt;
        reset = 1'b0;
        tick();
        chk("abort busy/valid/done", 32'({busy, dout_valid, done}), 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no activity after abort", 32'({busy, mem_rd, done}), 0);
        end
        chk("no done on abort", 32'(done_cnt), 32'(d0));
        chk("abort queue drained", 32'(exp_q.size()), 0);
        push_range(4'h0, 4'hF);
        pulse_start();
        chk("post-abort mem_addr", 32'({mem_rd, mem_addr}), 32'({1'b1, 4'h0}));
        wait_done("post-abort dump done", -1);
        tick();
        // sub-range instance 9h..Ah
        exp2_q.push_back({4'h9, 8'h0A});
        exp2_q.push_back({4'hA, 8'h0B});
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("dut2 first read", 32'({mem_rd2, mem_addr2, dout_valid2}), 32'({1'b1, 4'h9, 1'b0}));
        tick();
        tick();
        chk("dut2 first byte at T+3", 32'({dout_valid2, dout_addr2, dout2}), 32'({1'b1, 4'h9, 8'h0A}));
        tick();
        tick();
        tick();
        chk("dut2 no early done", 32'(done2), 0);
        tick();
        chk("dut2 done after second handshake", 32'(done2), 1);
        tick();
        chk("dut2 done pulse count", 32'(done2_cnt), 1);
        chk("dut2 idle", 32'(busy2), 0);
        chk("queue empty", 32'(exp_q.size()), 0);
        chk("queue2 empty", 32'(exp2_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_dump_reader.md
RAM_DUMP_READER -- requirements
Module: ram_dump_reader

Interface
REQ-001 Parameter START_ADDR, default 4'h0: first RAM address read in a dump.
REQ-002 Parameter END_ADDR, default 4'hF: last RAM address read in a dump; START_ADDR <= END_ADDR.
REQ-003 Parameter AUTO_ON_HLT, default 1: when 1, a rising edge of HLT starts a dump.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  dump request, sampled only in IDLE.
REQ-007 HLT  input  1  CPU halt flag from the control sequencer.
REQ-008 mem_rd  output  1  RAM read strobe; RAM returns data one cycle later.
REQ-009 mem_addr  output  4  RAM address for the read.
REQ-010 mem_data  input  8  RAM read data, valid the cycle after mem_rd.
REQ-011 dout  output  8  captured RAM byte.
REQ-012 dout_addr  output  4  address dout was read from.
REQ-013 dout_valid  output  1  dout/dout_addr valid; held until accepted.
REQ-014 dout_ready  input  1  consumer accepts when dout_valid && dout_ready.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  single-cycle pulse after the last byte is accepted.

Function
REQ-017 FSM states SHALL be IDLE, REQ, CAPT, SEND, FIN.
REQ-018 IDLE -> REQ when start=1, or when AUTO_ON_HLT=1 and HLT is 1 this cycle and was 0 the previous cycle; the address counter loads START_ADDR.
REQ-019 REQ: mem_rd=1 and mem_addr=counter for exactly one cycle; the next state is always CAPT.
REQ-020 CAPT: dout<=mem_data and dout_addr<=counter; the next state is SEND.
REQ-021 SEND: dout_valid=1; dout and dout_addr stable until the handshake.
REQ-022 SEND handshake with counter != END_ADDR: counter+1, next state REQ.
REQ-023 SEND handshake with counter == END_ADDR: next state FIN; the counter does not increment and never wraps past 4'hF.
REQ-024 FIN: done=1 for one cycle; the next state is IDLE.
REQ-025 Latency: trigger cycle T gives mem_rd at T+1, dout_valid at T+3; with dout_ready tied high, one byte every 3 cycles.
REQ-026 start or HLT edges while busy SHALL be ignored; they are not queued.
REQ-027 Outside REQ, mem_rd=0 and mem_addr=0.
REQ-028 The previous-HLT register SHALL update every cycle, including while busy.

Reset
REQ-029 reset=0 at a clock edge: state IDLE; counter, dout, dout_addr and the previous-HLT register cleared to 0.
REQ-030 While in reset: mem_rd, dout_valid, busy and done are 0.
REQ-031 Reset mid-dump aborts immediately; no done pulse is generated and no further reads occur.

Verification
REQ-032 RAM preloaded 0h=79h, 9h=0Ah, Ah=0Bh, other locations 00h, dout_ready=1, start pulse -> 16 bytes (0h,79h), (1h,00h)...(9h,0Ah), (Ah,0Bh)...(Fh,00h), then one done pulse.
REQ-033 START_ADDR=9, END_ADDR=A, start -> exactly (9h,0Ah) then (Ah,0Bh); first dout_valid 3 cycles after start; done 1 cycle after the second handshake.
REQ-034 dout_ready held 0 for 5 cycles on byte 9h -> dout=0Ah and dout_addr=9h stable, no mem_rd during the stall; the dump resumes the cycle after dout_ready=1.
REQ-035 HLT rises 0->1 and stays 1 -> one dump only; a second start while busy=1 is ignored; a new start after done starts a fresh dump from START_ADDR.
REQ-036 reset=0 while in SEND at address 5h -> next cycle busy=0, dout_valid=0, done never pulses; a later start dumps from START_ADDR.
